// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MIPS-subset datapath.
// Sequences IF/ID/EXE/MEM/WB with a memory ready handshake; outputs are combinational from state and inputs.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] pc_src,
    output logic [2:0] ALUctr,
    output logic       instr_done,
    output logic       illegal,
    output logic [2:0] state
);

    localparam int unsigned SW = 3;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] B_REG  = 2'b00;
    localparam logic [1:0] B_FOUR = 2'b01;
    localparam logic [1:0] B_IMM  = 2'b10;
    localparam logic [1:0] B_BOFS = 2'b11;

    localparam logic [1:0] PC_ALU  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JUMP = 2'b10;

    typedef enum logic [SW-1:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd7
    } state_t;

    state_t state_q;
    state_t state_d;

    logic       is_r;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_addi;
    logic       is_ori;
    logic       is_j;
    logic       funct_ok;
    logic       legal;
    logic [2:0] alu_r;

    // Instruction decode shared by next-state and output logic
    always_comb begin
        is_r     = (op == OP_R);
        is_lw    = (op == OP_LW);
        is_sw    = (op == OP_SW);
        is_beq   = (op == OP_BEQ);
        is_addi  = (op == OP_ADDI);
        is_ori   = (op == OP_ORI);
        is_j     = (op == OP_J);
        funct_ok = 1'b1;
        alu_r    = ALU_ADD;
        case (funct)
            FN_ADD:  alu_r = ALU_ADD;
            FN_SUB:  alu_r = ALU_SUB;
            FN_AND:  alu_r = ALU_AND;
            FN_OR:   alu_r = ALU_OR;
            FN_SLT:  alu_r = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
        legal = (is_r && funct_ok) || is_lw || is_sw || is_beq
              || is_addi || is_ori || is_j;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: begin
                if (mem_ready) begin
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (!legal) begin
                    state_d = S_ERR;
                end else if (is_j) begin
                    state_d = S_IF;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                // op is stable after ID; anything unexpected here is treated as an error
                if (!legal) begin
                    state_d = S_ERR;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_beq) begin
                    state_d = S_IF;
                end else if (is_r || is_addi || is_ori) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_MEM: begin
                if (!(is_lw || is_sw)) begin
                    state_d = S_ERR;
                end else if (mem_ready) begin
                    state_d = is_lw ? S_WB : S_IF;
                end
            end
            S_WB:    state_d = S_IF;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    // Output logic
    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = B_REG;
        ext_zero   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = PC_ALU;
        ALUctr     = ALU_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        state      = SW'(state_q);

        case (state_q)
            S_IF: begin
                mem_re    = 1'b1;
                alu_src_b = B_FOUR;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            S_ID: begin
                alu_src_b = B_BOFS;
                if (legal && is_j) begin
                    pc_we      = 1'b1;
                    pc_src     = PC_JUMP;
                    instr_done = 1'b1;
                end
            end
            S_EXE: begin
                if (legal) begin
                    if (is_r) begin
                        alu_src_a = 1'b1;
                        alu_src_b = B_REG;
                        ALUctr    = alu_r;
                    end else if (is_lw || is_sw || is_addi) begin
                        alu_src_a = 1'b1;
                        alu_src_b = B_IMM;
                    end else if (is_ori) begin
                        alu_src_a = 1'b1;
                        alu_src_b = B_IMM;
                        ext_zero  = 1'b1;
                        ALUctr    = ALU_OR;
                    end else if (is_beq) begin
                        alu_src_a  = 1'b1;
                        alu_src_b  = B_REG;
                        ALUctr     = ALU_SUB;
                        pc_src     = PC_BR;
                        pc_we      = zero;
                        instr_done = 1'b1;
                    end
                end
            end
            S_MEM: begin
                if (is_lw) begin
                    mem_re = 1'b1;
                end else if (is_sw) begin
                    mem_we     = 1'b1;
                    instr_done = mem_ready;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
                reg_dst    = is_r;
                mem_to_reg = is_lw;
            end
            S_ERR: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase

        // Reset abandons any in-flight instruction without a partial write
        if (rst) begin
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            reg_we     = 1'b0;
            mem_re     = 1'b0;
            mem_we     = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = B_REG;
            ext_zero   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            pc_src     = PC_ALU;
            ALUctr     = ALU_ADD;
            instr_done = 1'b0;
            illegal    = 1'b0;
            state      = SW'(S_IF);
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed, table-driven bench for mc_ctrl: per-cycle vectors plus CPI and invariant checks.
module tb_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_we, ir_we, reg_we, mem_re, mem_we, alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero, reg_dst, mem_to_reg;
    logic [1:0] pc_src;
    logic [2:0] ALUctr;
    logic       instr_done, illegal;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    mc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_zero   (ext_zero),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .pc_src     (pc_src),
        .ALUctr     (ALUctr),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw, irw, rgw, mre, mwe, asa;
        logic [1:0] asb;
        logic       ext, rdst, m2r;
        logic [1:0] psrc;
        logic [2:0] alu;
        logic       done, ill;
    } outs_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    vec_t vecs[$];

    function automatic outs_t o(input logic [2:0] st, input logic pcw, input logic irw,
                                input logic rgw, input logic mre, input logic mwe,
                                input logic asa, input logic [1:0] asb, input logic ext,
                                input logic rdst, input logic m2r, input logic [1:0] psrc,
                                input logic [2:0] alu, input logic done, input logic ill);
        outs_t r;
        r = '{st, pcw, irw, rgw, mre, mwe, asa, asb, ext, rdst, m2r, psrc, alu, done, ill};
        return r;
    endfunction

    function automatic outs_t actual();
        return o(state, pc_we, ir_we, reg_we, mem_re, mem_we, alu_src_a, alu_src_b,
                 ext_zero, reg_dst, mem_to_reg, pc_src, ALUctr, instr_done, illegal);
    endfunction

    task automatic add(input string nm, input logic r, input logic [5:0] o_op,
                       input logic [5:0] o_fn, input logic z, input logic rd, input outs_t e);
        vec_t v;
        v.name = nm; v.rst = r; v.op = o_op; v.funct = o_fn; v.zero = z; v.rdy = rd; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Invariants sampled every cycle outside reset
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            check("mem_re_and_mem_we", 32'(mem_re & mem_we), 32'd0);
            check("done_back_to_back", 32'(instr_done & prev_done), 32'd0);
            prev_done = instr_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic run_cpi(input string nm, input logic [5:0] o_op, input logic [5:0] o_fn,
                           input int exp_cyc);
        int cyc;
        rst = 1'b1; op = o_op; funct = o_fn; zero = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!instr_done && cyc < 20);
        check(nm, 32'(cyc), 32'(exp_cyc));
    endtask

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SWO = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, J = 6'b000010, BAD = 6'b111111;
    localparam logic [5:0] F_SUB = 6'b100010, F_SLT = 6'b101010, F_ADD = 6'b100000;

    outs_t RST, IF_GO, IF_WAIT, ID, ID_J, EX_SUB, EX_SLT, EX_ADR, EX_ORI, EX_BQ1, EX_BQ0;
    outs_t MEM_LW, MEM_SW_W, MEM_SW, WB_R, WB_LW, WB_I, ERR;

    initial begin
        rst = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

        //          st  pcw irw rgw mre mwe asa asb    ext rd m2r psrc   alu     dn ill
        RST      = o(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'b010, 0, 0);
        IF_GO    = o(0, 1, 1, 0, 1, 0, 0, 2'b01, 0, 0, 0, 2'b00, 3'b010, 0, 0);
        IF_WAIT  = o(0, 0, 0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 2'b00, 3'b010, 0, 0);
        ID       = o(1, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 2'b00, 3'b010, 0, 0);
        ID_J     = o(1, 1, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 2'b10, 3'b010, 1, 0);
        EX_SUB   = o(2, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 2'b00, 3'b110, 0, 0);
        EX_SLT   = o(2, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 2'b00, 3'b111, 0, 0);
        EX_ADR   = o(2, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 2'b00, 3'b010, 0, 0);
        EX_ORI   = o(2, 0, 0, 0, 0, 0, 1, 2'b10, 1, 0, 0, 2'b00, 3'b001, 0, 0);
        EX_BQ1   = o(2, 1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 2'b01, 3'b110, 1, 0);
        EX_BQ0   = o(2, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 2'b01, 3'b110, 1, 0);
        MEM_LW   = o(3, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'b010, 0, 0);
        MEM_SW_W = o(3, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 3'b010, 0, 0);
        MEM_SW   = o(3, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 3'b010, 1, 0);
        WB_R     = o(4, 0, 0, 1, 0, 0, 0, 2'b00, 0, 1, 0, 2'b00, 3'b010, 1, 0);
        WB_LW    = o(4, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 1, 2'b00, 3'b010, 1, 0);
        WB_I     = o(4, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'b010, 1, 0);
        ERR      = o(7, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'b010, 0, 1);

        add("rst0", 1, R, F_SUB, 0, 1, RST);
        add("rst1", 1, R, F_SUB, 0, 1, RST);
        add("rst2", 1, R, F_SUB, 0, 1, RST);
        add("sub_if", 0, R, F_SUB, 0, 1, IF_GO);
        add("sub_id", 0, R, F_SUB, 0, 1, ID);
        add("sub_ex", 0, R, F_SUB, 0, 1, EX_SUB);
        add("sub_wb", 0, R, F_SUB, 0, 1, WB_R);
        add("lw_if", 0, LW, 6'd0, 0, 1, IF_GO);
        add("lw_id", 0, LW, 6'd0, 0, 1, ID);
        add("lw_ex", 0, LW, 6'd0, 0, 1, EX_ADR);
        add("lw_mem_w0", 0, LW, 6'd0, 0, 0, MEM_LW);
        add("lw_mem_w1", 0, LW, 6'd0, 0, 0, MEM_LW);
        add("lw_mem", 0, LW, 6'd0, 0, 1, MEM_LW);
        add("lw_wb", 0, LW, 6'd0, 0, 1, WB_LW);
        add("sw_if_w", 0, SWO, 6'd0, 0, 0, IF_WAIT);
        add("sw_if", 0, SWO, 6'd0, 0, 1, IF_GO);
        add("sw_id", 0, SWO, 6'd0, 0, 1, ID);
        add("sw_ex", 0, SWO, 6'd0, 0, 1, EX_ADR);
        add("sw_mem_w", 0, SWO, 6'd0, 0, 0, MEM_SW_W);
        add("sw_mem", 0, SWO, 6'd0, 0, 1, MEM_SW);
        add("beq1_if", 0, BEQ, 6'd0, 1, 1, IF_GO);
        add("beq1_id", 0, BEQ, 6'd0, 1, 1, ID);
        add("beq1_ex", 0, BEQ, 6'd0, 1, 1, EX_BQ1);
        add("beq0_if", 0, BEQ, 6'd0, 0, 1, IF_GO);
        add("beq0_id", 0, BEQ, 6'd0, 0, 1, ID);
        add("beq0_ex", 0, BEQ, 6'd0, 0, 1, EX_BQ0);
        add("j_if", 0, J, 6'd0, 0, 1, IF_GO);
        add("j_id", 0, J, 6'd0, 0, 1, ID_J);
        add("ori_if", 0, ORI, 6'd0, 0, 1, IF_GO);
        add("ori_id", 0, ORI, 6'd0, 0, 1, ID);
        add("ori_ex", 0, ORI, 6'd0, 0, 1, EX_ORI);
        add("ori_wb", 0, ORI, 6'd0, 0, 1, WB_I);
        add("addi_if", 0, ADDI, 6'd0, 0, 1, IF_GO);
        add("addi_id", 0, ADDI, 6'd0, 0, 1, ID);
        add("addi_ex", 0, ADDI, 6'd0, 0, 1, EX_ADR);
        add("addi_wb", 0, ADDI, 6'd0, 0, 1, WB_I);
        add("slt_if", 0, R, F_SLT, 0, 1, IF_GO);
        add("slt_id", 0, R, F_SLT, 0, 1, ID);
        add("slt_ex", 0, R, F_SLT, 0, 1, EX_SLT);
        add("slt_wb", 0, R, F_SLT, 0, 1, WB_R);
        add("badop_if", 0, BAD, 6'd0, 0, 1, IF_GO);
        add("badop_id", 0, BAD, 6'd0, 0, 1, ID);
        add("badop_err0", 0, BAD, 6'd0, 0, 1, ERR);
        add("badop_err1", 0, R, F_ADD, 1, 1, ERR);
        add("badop_rst", 1, R, F_ADD, 0, 1, RST);
        add("badfn_if", 0, R, 6'd0, 0, 1, IF_GO);
        add("badfn_id", 0, R, 6'd0, 0, 1, ID);
        add("badfn_err", 0, R, 6'd0, 0, 1, ERR);
        add("badfn_rst", 1, R, 6'd0, 0, 1, RST);
        add("midrst_if", 0, LW, 6'd0, 0, 1, IF_GO);
        add("midrst_id", 0, LW, 6'd0, 0, 1, ID);
        add("midrst_ex", 0, LW, 6'd0, 0, 1, EX_ADR);
        add("midrst_rst", 1, LW, 6'd0, 0, 1, RST);
        add("midrst_if2", 0, LW, 6'd0, 0, 1, IF_GO);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct;
            zero = vecs[i].zero; mem_ready = vecs[i].rdy;
            @(negedge clk);
            check(vecs[i].name, 32'(actual()), 32'(vecs[i].exp));
            @(posedge clk); #1;
        end

        run_cpi("cpi_j", J, 6'd0, 2);
        run_cpi("cpi_beq", BEQ, 6'd0, 3);
        run_cpi("cpi_sw", SWO, 6'd0, 4);
        run_cpi("cpi_add", R, F_ADD, 4);
        run_cpi("cpi_addi", ADDI, 6'd0, 4);
        run_cpi("cpi_ori", ORI, 6'd0, 4);
        run_cpi("cpi_lw", LW, 6'd0, 5);

        rst = 1'b1;
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the single-issue MIPS-subset datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states, drives all datapath write enables and mux selects, and produces the 3-bit `ALUctr` code consumed by the ALU control decoder. Memory accesses use a ready handshake so that slow instruction and data memories stall the sequence cleanly.

## Interface
- No parameters.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `op` input 6: opcode field `IR[31:26]`. Valid from state ID until the next IR write.
- `funct` input 6: function field `IR[5:0]`.
- `zero` input 1: ALU zero flag for the current-cycle ALU result.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pc_we` output 1: PC write enable.
- `ir_we` output 1: IR write enable.
- `reg_we` output 1: register file write enable.
- `mem_re` output 1: memory read request.
- `mem_we` output 1: memory write request.
- `alu_src_a` output 1: ALU A input select. 0 = PC, 1 = register A.
- `alu_src_b` output 2: ALU B input select. 00 = register B, 01 = constant 4, 10 = extended immediate, 11 = sign-extended immediate shifted left by 2.
- `ext_zero` output 1: immediate extension mode. 1 = zero-extend (ori), 0 = sign-extend.
- `reg_dst` output 1: destination register select. 1 = rd, 0 = rt.
- `mem_to_reg` output 1: write-back data select. 1 = memory data, 0 = ALUOut.
- `pc_src` output 2: PC source select. 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- `ALUctr` output 3: ALU operation. 000 = AND, 001 = OR, 010 = ADD, 110 = SUB, 111 = SLT.
- `instr_done` output 1: one-cycle pulse on the final cycle of each retired instruction.
- `illegal` output 1: sticky error flag.
- `state` output 3: current state, for debug.

## Operation
- **Supported instructions**
  - R-type (op 000000) with these funct values: add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - lw 100011, sw 101011, beq 000100, addi 001000, ori 001101, j 000010.
  - Any other op, or an R-type with any other funct, is illegal.
- **State encoding:** IF = 0, ID = 1, EXE = 2, MEM = 3, WB = 4, ERR = 7. Codes 5 and 6 are unused; if reached, the next state is ERR.
- **Default outputs:** all enables and selects are 0, and `ALUctr` = 010.
- **IF**
  - Outputs: `mem_re`=1, `alu_src_a`=0, `alu_src_b`=01, `ALUctr`=010.
  - If `mem_ready`=1: assert `ir_we`=1 and `pc_we`=1 (`pc_src`=00), then go to ID. Otherwise stay in IF with all write enables at 0.
- **ID**
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `ALUctr`=010 (branch target computed into ALUOut).
  - Illegal instruction: go to ERR.
  - j: `pc_we`=1, `pc_src`=10, `instr_done`=1, then go to IF.
  - All other legal instructions: go to EXE.
- **EXE**
  - R-type: `alu_src_a`=1, `alu_src_b`=00, `ALUctr` decoded from funct (add 010, sub 110, and 000, or 001, slt 111). Next state WB.
  - lw, sw, addi: `alu_src_a`=1, `alu_src_b`=10, `ALUctr`=010. lw and sw go to MEM; addi goes to WB.
  - ori: `alu_src_a`=1, `alu_src_b`=10, `ext_zero`=1, `ALUctr`=001. Next state WB.
  - beq: `alu_src_a`=1, `alu_src_b`=00, `ALUctr`=110, `pc_src`=01, `pc_we`=`zero`, `instr_done`=1. Next state IF.
- **MEM**
  - lw asserts `mem_re`; sw asserts `mem_we`. The request is held until `mem_ready`=1.
  - On `mem_ready`: lw goes to WB; sw asserts `instr_done`=1 and goes to IF.
- **WB**
  - `reg_we`=1 and `instr_done`=1, then go to IF.
  - `reg_dst`=1 for R-type, 0 otherwise.
  - `mem_to_reg`=1 for lw only.
- **ERR**
  - `illegal`=1; all enables 0.
  - Remains in ERR until `rst`.
- **Reset**
  - Next state is IF and `illegal` clears.
  - While `rst`=1, every enable and `instr_done` is forced to 0, and `state` reads 0.
  - A reset asserted mid-instruction abandons it; no partial write may occur in the reset cycle.

## Timing
- State is registered. Outputs are combinational from `state`, `op`, `funct`, `zero` and `mem_ready`; there are no output registers.
- Cycles per instruction with `mem_ready` tied high:
  - j: 2
  - beq: 3
  - sw, R-type, addi, ori: 4
  - lw: 5
- Each cycle with `mem_ready`=0 in IF or MEM adds exactly one cycle; the request stays asserted and the outputs are unchanged.
- `instr_done` is high for exactly one cycle per instruction; two pulses are always separated by at least one cycle.
- `mem_re` and `mem_we` are never asserted together.
- `pc_we` is asserted at most once per instruction after the IF write.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles, then release with `mem_ready`=1 -> `state`=0, all enables 0 during reset; the first cycle after release shows `mem_re`=1, `ir_we`=1, `pc_we`=1.
- **R-type sub:** `mem_ready`=1, op=000000, funct=100010 -> states 0,1,2,4; `ALUctr`=110 in EXE; WB shows `reg_we`=1, `reg_dst`=1, `instr_done`=1; 4 cycles total.
- **lw with stalls:** op=100011, `mem_ready` held low for 2 cycles in MEM -> `mem_re` held for 3 MEM cycles; WB shows `mem_to_reg`=1, `reg_dst`=0; 7 cycles total.
- **beq:** op=000100 with `zero`=1 -> in EXE `pc_we`=1, `pc_src`=01, `ALUctr`=110. With `zero`=0 -> `pc_we`=0. Both cases take 3 cycles.
- **j and ori:** j returns to IF after 2 cycles with `pc_src`=10. ori shows `ALUctr`=001 and `ext_zero`=1 in EXE.
- **Illegal:** op=111111, or funct=000000 with R-type -> ERR at the cycle after ID, `illegal`=1, no enables until `rst`; a subsequent `rst` returns to IF.
